// File: rtl/seq_booth_multiplier_if.sv
// Operand/result handshake bundle for seq_booth_multiplier.
// master = operand producer / result consumer side, slave = multiplier side.
interface seq_booth_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   signed_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-4 Booth multiplier, signed/unsigned selectable per operation.
// Latency: WIDTH/2+2 cycles from accept to out_valid; one operation in flight.
// Backpressure: result held in DONE until out_ready; a new accept may share that edge.
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_booth_multiplier_if.slave   bus
);
    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;        // extended operand width
    localparam int AW   = EW + 2;           // accumulator headroom for +-2M
    localparam int CW   = $clog2(ITER + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("seq_booth_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   ready;
    logic                   accept;

    logic [CW-1:0]          cnt;
    logic [EW-1:0]          mcand;
    logic signed [AW-1:0]   acc;
    logic [EW-1:0]          mplr;
    logic                   mplr_lsb;
    logic [2*WIDTH-1:0]     result_q;

    logic signed [AW-1:0]   pp;
    logic signed [AW-1:0]   sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready = ~rst;
                if (bus.in_valid && !rst) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready = bus.out_ready & ~rst;
                if (bus.out_ready) begin
                    accept    = bus.in_valid & ~rst;
                    state_nxt = bus.in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Booth digit from {b[2i+1], b[2i], b[2i-1]} selects 0, +-M or +-2M.
    always_comb begin
        pp = '0;
        case ({mplr[1:0], mplr_lsb})
            3'b001, 3'b010: pp =  {{2{mcand[EW-1]}}, mcand};
            3'b011:         pp =  {mcand[EW-1], mcand, 1'b0};
            3'b100:         pp = -{mcand[EW-1], mcand, 1'b0};
            3'b101, 3'b110: pp = -{{2{mcand[EW-1]}}, mcand};
            default:        pp = '0;
        endcase
        sum = acc + pp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mcand    <= '0;
            acc      <= '0;
            mplr     <= '0;
            mplr_lsb <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            mcand    <= {{2{bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};
            mplr     <= {{2{bus.signed_mode & bus.b[WIDTH-1]}}, bus.b};
            mplr_lsb <= 1'b0;
            acc      <= '0;
            cnt      <= CW'(ITER);
        end else if (state == RUN) begin
            if (cnt != '0) begin
                // Product bits retire into the multiplier register as it empties.
                acc      <= sum >>> 2;
                mplr     <= {sum[1:0], mplr[EW-1:2]};
                mplr_lsb <= mplr[1];
                cnt      <= cnt - 1'b1;
            end else begin
                result_q <= {acc[WIDTH-3:0], mplr};
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN);
    assign bus.result    = result_q;
endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Parametrised iterative radix-4 Booth multiplier; the next generation of the sequential CSA tree multiplier. Adds a generic operand width, run-time signed/unsigned mode and valid/ready handshakes on both the input and output sides. It sits between operand producers and accumulator/datapath consumers where area matters more than throughput.

Parameters:
WIDTH, 32, operand width in bits; must be even and ≥4 (elaboration error otherwise).
ITER, WIDTH/2+1, derived localparam: Booth iterations per operation; not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands a/b/signed_mode valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  product
busy  output  1  high in RUN state

Behaviour:
- Synchronous active-high reset; clk/rst as above; no other clocks.
- States: IDLE, RUN, DONE. Reset → IDLE; out_valid=0, result=0, busy=0, iteration counter=0, internal operand registers=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; in_ready is 0 during reset.
- Accept: in_valid & in_ready at a rising edge captures a, b and signed_mode → RUN, counter=ITER.
- Operands are extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise. Multiplier gets an appended 0 LSB.
- RUN: each cycle examines 3 multiplier bits and adds 0, ±M or ±2M to the upper partial product. It then shifts the product/multiplier pair right by 2, arithmetically, and decrements the counter. After the ITER-th iteration → DONE.
- Latency: accept at edge k → out_valid=1 and result valid after edge k+ITER+1 (WIDTH=32: 18 cycles; WIDTH=8: 6 cycles).
- result = exact 2*WIDTH-bit product in the selected mode; no overflow is possible. The most-negative × most-negative signed case is exact.
- DONE: out_valid=1; result held stable until out_valid & out_ready.
  - Handshake without a new accept → IDLE, out_valid=0. result keeps its last value.
  - Handshake with a simultaneous in_valid → new operands accepted that edge → RUN. out_valid drops. No bubble beyond the RUN time.
- in_valid is ignored while in RUN, and in DONE when out_ready=0. Operand inputs may change freely after accept.
- out_ready is ignored outside DONE.
- busy=1 exactly in RUN.
- rst asserted in any state, including mid-RUN: next state IDLE, all outputs at reset values, the in-flight operation is discarded, and no out_valid is produced for it.
- Mode is latched per operation; toggling signed_mode after accept has no effect.

Test Plan:
- WIDTH=32, signed: a=95262, b=-545854 → result=-51999143748, out_valid exactly 18 cycles after accept.
- WIDTH=32, unsigned a=b=32'hFFFFFFFF → 64'hFFFFFFFE00000001. The same operands in signed mode → 64'h0000000000000001.
- WIDTH=32, signed a=b=32'h80000000 → 64'h4000000000000000. Also signed a=0, b=12345 → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, and in_valid pulses ignored. Then assert out_ready with in_valid (a=-3265, b=-89261) on the same edge → accepted with no gap; result=291437165.
- Reset mid-op: assert rst on the 8th RUN cycle → next cycle in_ready=1, out_valid=0, result=0. A following op a=1, b=44512 → result=44512.
- WIDTH=8, signed a=-56, b=12 → 16'hFD60 after 6 cycles. Unsigned a=8'hC8, b=12 → 16'h0960.
